// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one req/ack data-memory transaction per op, misalignment faults.
// Optional LSU_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES cycles without mem_ack.
module lsu
`ifdef LSU_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  alucode,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic        resp_we,
   output logic [4:0]  rd_out,
   output logic [31:0] rdata,
   output logic        fault
);

   localparam logic [5:0] ALU_LB  = 6'd20;
   localparam logic [5:0] ALU_LH  = 6'd21;
   localparam logic [5:0] ALU_LW  = 6'd22;
   localparam logic [5:0] ALU_LBU = 6'd23;
   localparam logic [5:0] ALU_LHU = 6'd24;
   localparam logic [5:0] ALU_SB  = 6'd25;
   localparam logic [5:0] ALU_SH  = 6'd26;
   localparam logic [5:0] ALU_SW  = 6'd27;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;
   logic        resp_we_q, resp_we_d;

`ifdef LSU_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   logic        is_mem, is_store, misal, dec_uns;
   logic [1:0]  dec_size;
   logic [3:0]  dec_be;
   logic [31:0] dec_wdata;

   // Size: 0 = byte, 1 = half, 2 = word.
   always_comb begin
      is_mem   = 1'b1;
      is_store = 1'b0;
      dec_size = 2'd2;
      dec_uns  = 1'b0;
      case (alucode)
         ALU_LB:  dec_size = 2'd0;
         ALU_LH:  dec_size = 2'd1;
         ALU_LW:  dec_size = 2'd2;
         ALU_LBU: begin dec_size = 2'd0; dec_uns = 1'b1; end
         ALU_LHU: begin dec_size = 2'd1; dec_uns = 1'b1; end
         ALU_SB:  begin dec_size = 2'd0; is_store = 1'b1; end
         ALU_SH:  begin dec_size = 2'd1; is_store = 1'b1; end
         ALU_SW:  begin dec_size = 2'd2; is_store = 1'b1; end
         default: is_mem = 1'b0;
      endcase
      misal = ((dec_size == 2'd2) && (addr[1:0] != 2'b00)) ||
              ((dec_size == 2'd1) && addr[0]);
      case (dec_size)
         2'd0:    begin dec_be = 4'b0001 << addr[1:0];               dec_wdata = {4{wdata[7:0]}};  end
         2'd1:    begin dec_be = addr[1] ? 4'b1100 : 4'b0011;        dec_wdata = {2{wdata[15:0]}}; end
         default: begin dec_be = 4'b1111;                             dec_wdata = wdata;            end
      endcase
   end

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;

   always_comb begin
      ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (size_q)
         2'd0:    ld_val = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'd1:    ld_val = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_val = mem_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      size_d    = size_q;
      uns_d     = uns_q;
      rdata_d   = rdata_q;
      fault_d   = fault_q;
      resp_we_d = resp_we_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Non-memory ops are accepted here and simply dropped.
            if (req_valid && is_mem) begin
               we_d      = is_store;
               addr_d    = addr;
               be_d      = dec_be;
               wdata_d   = is_store ? dec_wdata : 32'b0;
               rd_d      = rd_in;
               size_d    = dec_size;
               uns_d     = dec_uns;
               rdata_d   = 32'b0;
               fault_d   = misal;
               resp_we_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
               cnt_d     = '0;
`endif
               state_d   = misal ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (mem_ack) begin
               state_d = S_RESP;
               if (!we_q) begin
                  rdata_d   = ld_val;
                  resp_we_d = 1'b1;
               end
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               state_d = S_RESP;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         we_q      <= 1'b0;
         addr_q    <= 32'b0;
         be_q      <= 4'b0;
         wdata_q   <= 32'b0;
         rd_q      <= 5'b0;
         size_q    <= 2'b0;
         uns_q     <= 1'b0;
         rdata_q   <= 32'b0;
         fault_q   <= 1'b0;
         resp_we_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         rdata_q   <= rdata_d;
         fault_q   <= fault_d;
         resp_we_q <= resp_we_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign mem_req    = (state_q == S_ACCESS);
   assign mem_we     = we_q;
   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_be     = be_q;
   assign mem_wdata  = wdata_q;
   assign resp_valid = (state_q == S_RESP);
   assign resp_we    = (state_q == S_RESP) && resp_we_q;
   assign rd_out     = rd_q;
   assign rdata      = (state_q == S_RESP) ? rdata_q : 32'b0;
   assign fault      = (state_q == S_RESP) && fault_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed vector bench for lsu; timeout sequence only with LSU_TIMEOUT_EN (TIMEOUT_CYCLES=4).
module tb_lsu;

   localparam logic [5:0] ALU_ADD = 6'd0;
   localparam logic [5:0] ALU_LB  = 6'd20;
   localparam logic [5:0] ALU_LH  = 6'd21;
   localparam logic [5:0] ALU_LW  = 6'd22;
   localparam logic [5:0] ALU_LBU = 6'd23;
   localparam logic [5:0] ALU_LHU = 6'd24;
   localparam logic [5:0] ALU_SB  = 6'd25;
   localparam logic [5:0] ALU_SH  = 6'd26;
   localparam logic [5:0] ALU_SW  = 6'd27;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  alucode = 6'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [4:0]  rd_in = 5'd0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        resp_valid, resp_we, fault;
   logic [4:0]  rd_out;
   logic [31:0] rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
   lsu #(.TIMEOUT_CYCLES(4)) dut (
`else
   lsu dut (
`endif
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .alucode(alucode), .addr(addr), .wdata(wdata), .rd_in(rd_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_we(resp_we), .rd_out(rd_out),
      .rdata(rdata), .fault(fault)
   );

   typedef struct {
      logic [5:0]  code;
      logic [31:0] a;
      logic [31:0] wd;
      logic [4:0]  rd;
      int          delay;
      logic [31:0] mrdata;
      logic [31:0] e_maddr;
      logic [3:0]  e_be;
      logic        e_we;
      logic [31:0] e_mwdata;
      logic        e_resp_we;
      logic [31:0] e_rdata;
      logic        e_fault;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string t;
      t = $sformatf("v%0d", idx);
      chk({t, ".req_ready_idle"}, req_ready, 1);
      req_valid = 1'b1; alucode = v.code; addr = v.a; wdata = v.wd; rd_in = v.rd;
      @(negedge clk);
      req_valid = 1'b0; alucode = ALU_ADD; addr = 32'd0; wdata = 32'd0; rd_in = 5'd0;
      if (v.e_fault) begin
         chk({t, ".no_mem_req"}, mem_req, 0);
      end else begin
         for (int c = 1; c <= v.delay; c++) begin
            if (c > 1) @(negedge clk);
            chk({t, ".mem_req"}, mem_req, 1);
            chk({t, ".mem_addr"}, mem_addr, v.e_maddr);
            chk({t, ".mem_be"}, mem_be, v.e_be);
            chk({t, ".mem_we"}, mem_we, v.e_we);
            if (v.e_we) chk({t, ".mem_wdata"}, mem_wdata, v.e_mwdata);
            chk({t, ".req_ready_busy"}, req_ready, 0);
            chk({t, ".no_early_resp"}, resp_valid, 0);
            if (c == v.delay) begin
               mem_ack = 1'b1;
               mem_rdata = v.mrdata;
            end
         end
         @(negedge clk);
         mem_ack = 1'b0;
         mem_rdata = 32'h5A5A_5A5A;
      end
      chk({t, ".resp_valid"}, resp_valid, 1);
      chk({t, ".fault"}, fault, v.e_fault);
      chk({t, ".resp_we"}, resp_we, v.e_resp_we);
      chk({t, ".rdata"}, rdata, v.e_rdata);
      chk({t, ".rd_out"}, rd_out, v.rd);
      @(negedge clk);
      chk({t, ".resp_one_cycle"}, resp_valid, 0);
      chk({t, ".fault_one_cycle"}, fault, 0);
      chk({t, ".back_idle"}, req_ready, 1);
   endtask

   initial begin
      //          code     addr          wdata         rd  dly mrdata        maddr         be       we    mwdata        rwe   rdata         fault
      vecs[0]  = '{ALU_LW,  32'h0000_0100, 32'h0,        5'd5,  1, 32'hDEADBEEF, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
      vecs[1]  = '{ALU_LB,  32'h0000_0103, 32'h0,        5'd6,  1, 32'h80112233, 32'h0000_0100, 4'b1000, 1'b0, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
      vecs[2]  = '{ALU_LBU, 32'h0000_0103, 32'h0,        5'd6,  1, 32'h80112233, 32'h0000_0100, 4'b1000, 1'b0, 32'h0,        1'b1, 32'h00000080, 1'b0};
      vecs[3]  = '{ALU_SH,  32'h0000_0202, 32'h1234ABCD, 5'd7,  2, 32'h0,        32'h0000_0200, 4'b1100, 1'b1, 32'hABCDABCD, 1'b0, 32'h0,        1'b0};
      vecs[4]  = '{ALU_LW,  32'h0000_0101, 32'h0,        5'd8,  1, 32'h0,        32'h0,         4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
      vecs[5]  = '{ALU_LH,  32'h0000_0102, 32'h0,        5'd9,  3, 32'h80112233, 32'h0000_0100, 4'b1100, 1'b0, 32'h0,        1'b1, 32'hFFFF8011, 1'b0};
      vecs[6]  = '{ALU_LHU, 32'h0000_0100, 32'h0,        5'd10, 1, 32'h80112233, 32'h0000_0100, 4'b0011, 1'b0, 32'h0,        1'b1, 32'h00002233, 1'b0};
      vecs[7]  = '{ALU_SB,  32'h0000_0301, 32'h000000A5, 5'd11, 1, 32'h0,        32'h0000_0300, 4'b0010, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
      vecs[8]  = '{ALU_SW,  32'h0000_0400, 32'hCAFEF00D, 5'd12, 2, 32'h0,        32'h0000_0400, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
      vecs[9]  = '{ALU_SH,  32'h0000_0203, 32'h1111_2222, 5'd13, 1, 32'h0,       32'h0,         4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
      vecs[10] = '{ALU_LHU, 32'h0000_0101, 32'h0,        5'd14, 1, 32'h0,        32'h0,         4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
      vecs[11] = '{ALU_LB,  32'h0000_0101, 32'h0,        5'd15, 1, 32'h80112233, 32'h0000_0100, 4'b0010, 1'b0, 32'h0,        1'b1, 32'h00000022, 1'b0};
      vecs[12] = '{ALU_SW,  32'h0000_0402, 32'hFFFF_0000, 5'd16, 1, 32'h0,       32'h0,         4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};

      repeat (2) @(negedge clk);
      chk("rst.req_ready", req_ready, 1);
      chk("rst.mem_req", mem_req, 0);
      chk("rst.resp_valid", resp_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset.req_ready", req_ready, 1);
      chk("reset.mem_req", mem_req, 0);
      chk("reset.mem_we", mem_we, 0);
      chk("reset.mem_addr", mem_addr, 0);
      chk("reset.mem_be", mem_be, 0);
      chk("reset.mem_wdata", mem_wdata, 0);
      chk("reset.resp_valid", resp_valid, 0);
      chk("reset.resp_we", resp_we, 0);
      chk("reset.rd_out", rd_out, 0);
      chk("reset.rdata", rdata, 0);
      chk("reset.fault", fault, 0);

      for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

      // Non-memory op is dropped.
      req_valid = 1'b1; alucode = ALU_ADD; addr = 32'h100; rd_in = 5'd3;
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         chk("nonmem.mem_req", mem_req, 0);
         chk("nonmem.resp_valid", resp_valid, 0);
         chk("nonmem.req_ready", req_ready, 1);
         @(negedge clk);
      end

      // Delayed ack with upstream holding a new op, then reset mid-ACCESS.
      req_valid = 1'b1; alucode = ALU_LW; addr = 32'h0000_0500; rd_in = 5'd20;
      @(negedge clk);
      alucode = ALU_SW; addr = 32'h0000_0600; wdata = 32'h1234_5678;
      for (int c = 1; c <= 5; c++) begin
         chk("hold.mem_req", mem_req, 1);
         chk("hold.mem_addr", mem_addr, 32'h0000_0500);
         chk("hold.mem_we", mem_we, 0);
         chk("hold.mem_be", mem_be, 4'b1111);
         chk("hold.req_ready", req_ready, 0);
         @(negedge clk);
      end
      req_valid = 1'b0; alucode = ALU_ADD; addr = 32'd0; wdata = 32'd0;
      mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
      #2 rst = 1'b1;
      #1;
      chk("rstmid.mem_req", mem_req, 0);
      chk("rstmid.req_ready", req_ready, 1);
      chk("rstmid.resp_valid", resp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstack.resp_valid", resp_valid, 0);
      chk("rstack.mem_req", mem_req, 0);
      mem_ack = 1'b0;
      @(negedge clk);
      chk("rstack.resp_valid2", resp_valid, 0);
      chk("rstack.req_ready", req_ready, 1);

`ifdef LSU_TIMEOUT_EN
      req_valid = 1'b1; alucode = ALU_LW; addr = 32'h0000_0700; rd_in = 5'd21;
      @(negedge clk);
      req_valid = 1'b0; alucode = ALU_ADD; addr = 32'd0;
      for (int c = 1; c <= 4; c++) begin
         chk("tmo.mem_req", mem_req, 1);
         chk("tmo.no_resp", resp_valid, 0);
         @(negedge clk);
      end
      chk("tmo.mem_req_drop", mem_req, 0);
      chk("tmo.resp_valid", resp_valid, 1);
      chk("tmo.fault", fault, 1);
      chk("tmo.resp_we", resp_we, 0);
      chk("tmo.rdata", rdata, 0);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("tmo.late_ack_resp", resp_valid, 0);
      chk("tmo.late_ack_ready", req_ready, 1);
      @(negedge clk);
      mem_ack = 1'b0;
      chk("tmo.late_ack_resp2", resp_valid, 0);
      chk("tmo.late_ack_mem_req", mem_req, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
